// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of hazard_ctrl
interface hazard_ctrl_if #(parameter int REG_BITS = 5);
  logic id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic id_use_rs;
  logic id_use_rt;
  logic [REG_BITS-1:0] id_dest;
  logic id_wb_en;
  logic id_is_md;
  logic ex_mem_r_en;
  logic ex_wb_en;
  logic [REG_BITS-1:0] ex_dest;
  logic branch_taken;
  logic pc_hold;
  logic ifid_hold;
  logic idex_bubble;
  logic ifid_flush;
  logic md_start;
  logic md_busy;
  logic md_done;
  logic [REG_BITS-1:0] md_dest_out;
  logic [15:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wb_en, id_is_md,
    output ex_mem_r_en, ex_wb_en, ex_dest, branch_taken,
    input pc_hold, ifid_hold, idex_bubble, ifid_flush, md_start, md_busy, md_done,
    input md_dest_out, stall_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wb_en, id_is_md,
    input ex_mem_r_en, ex_wb_en, ex_dest, branch_taken,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, md_start, md_busy, md_done,
    output md_dest_out, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, mult/div scoreboard and taken-branch hold/flush control
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int REG_BITS = 5
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [REG_BITS-1:0] md_dest;
  logic [15:0] stall_cnt;
  logic run, busy, sb, lu, md_raw, md_waw, md_struct, stall, br;
  logic pc_hold, ifid_hold, idex_bubble, ifid_flush, md_start, md_busy, md_done;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      md_dest <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (md_start) md_dest <= bus.id_dest;
      if (pc_hold && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  always_comb begin
    state_n = state == IDLE ? (md_start ? BUSY : IDLE) :
              state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
    cnt_n = md_start ? 4'(MD_LATENCY - 1) : (state == BUSY && cnt != '0) ? cnt - 4'd1 : cnt;
  end
  // Stalls against the in-flight mult/div last through DONE, releasing once back in IDLE.
  always_comb begin
    run = bus.id_valid & !rst;
    busy = state != IDLE;
    sb = busy & (md_dest != '0);
    lu = run & bus.ex_mem_r_en & bus.ex_wb_en & (bus.ex_dest != '0) &
         ((bus.id_use_rs & (bus.id_rs == bus.ex_dest)) | (bus.id_use_rt & (bus.id_rt == bus.ex_dest)));
    md_raw = run & sb & ((bus.id_use_rs & (bus.id_rs == md_dest)) | (bus.id_use_rt & (bus.id_rt == md_dest)));
    md_waw = run & sb & bus.id_wb_en & (bus.id_dest == md_dest);
    md_struct = run & busy & bus.id_is_md;
    stall = lu | md_raw | md_waw | md_struct;
    br = bus.branch_taken & !rst;
    ifid_flush = br;
    idex_bubble = br | stall;
    pc_hold = !br & stall;
    ifid_hold = !br & stall;
    md_start = run & bus.id_is_md & !busy & !stall & !br;
    md_busy = busy & !rst;
    md_done = (state == DONE) & !rst;
  end
  assign bus.pc_hold = pc_hold;
  assign bus.ifid_hold = ifid_hold;
  assign bus.idex_bubble = idex_bubble;
  assign bus.ifid_flush = ifid_flush;
  assign bus.md_start = md_start;
  assign bus.md_busy = md_busy;
  assign bus.md_done = md_done;
  assign bus.md_dest_out = md_dest;
  assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with hand-computed expectations
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  hazard_ctrl_if #(.REG_BITS(5)) b ();
  hazard_ctrl #(.MD_LATENCY(4), .REG_BITS(5)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic clr();
    b.id_valid = 0; b.id_rs = 0; b.id_rt = 0; b.id_use_rs = 0; b.id_use_rt = 0;
    b.id_dest = 0; b.id_wb_en = 0; b.id_is_md = 0;
    b.ex_mem_r_en = 0; b.ex_wb_en = 0; b.ex_dest = 0; b.branch_taken = 0;
  endtask
  task automatic idi(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                     input logic [4:0] d, input logic wb, input logic md);
    b.id_valid = 1; b.id_rs = rs; b.id_rt = rt; b.id_use_rs = ur; b.id_use_rt = ut;
    b.id_dest = d; b.id_wb_en = wb; b.id_is_md = md;
  endtask
  task automatic exi(input logic mr, input logic wb, input logic [4:0] d);
    b.ex_mem_r_en = mr; b.ex_wb_en = wb; b.ex_dest = d;
  endtask
  initial begin
    clr();
    rst = 1;
    nxt(); exi(1, 1, 5); idi(5, 0, 1, 0, 0, 0, 0); b.branch_taken = 1; #1;
    chk("rst_pc_hold", b.pc_hold, 0);
    chk("rst_flush", b.ifid_flush, 0);
    chk("rst_bubble", b.idex_bubble, 0);
    nxt(); #1;
    chk("rst_busy", b.md_busy, 0);
    chk("rst_sc", b.stall_count, 0);
    chk("rst_dest", b.md_dest_out, 0);
    nxt(); rst = 0; clr();
    nxt(); exi(1, 1, 5); idi(5, 0, 1, 0, 1, 1, 0); #1;
    chk("lu_pc_hold", b.pc_hold, 1);
    chk("lu_ifid_hold", b.ifid_hold, 1);
    chk("lu_bubble", b.idex_bubble, 1);
    chk("lu_flush", b.ifid_flush, 0);
    nxt(); exi(0, 0, 0); #1;
    chk("lu_rel_hold", b.pc_hold, 0);
    chk("lu_rel_bubble", b.idex_bubble, 0);
    chk("lu_sc", b.stall_count, 1);
    nxt(); exi(1, 1, 0); idi(0, 0, 1, 1, 1, 1, 0); #1;
    chk("lu_r0", b.pc_hold, 0);
    nxt(); exi(1, 1, 5); idi(5, 0, 0, 0, 1, 1, 0); #1;
    chk("lu_nouse", b.pc_hold, 0);
    nxt(); exi(1, 0, 5); idi(5, 0, 1, 0, 1, 1, 0); #1;
    chk("lu_nowb", b.pc_hold, 0);
    nxt(); exi(1, 1, 5); idi(0, 5, 0, 1, 1, 1, 0); #1;
    chk("lu_rt", b.pc_hold, 1);
    nxt(); clr(); #1;
    chk("lu_sc2", b.stall_count, 2);
    nxt(); exi(1, 1, 5); idi(5, 0, 1, 0, 6, 1, 1); b.branch_taken = 1; #1;
    chk("br_flush", b.ifid_flush, 1);
    chk("br_bubble", b.idex_bubble, 1);
    chk("br_pc_hold", b.pc_hold, 0);
    chk("br_ifid_hold", b.ifid_hold, 0);
    chk("br_md_start", b.md_start, 0);
    nxt(); clr(); #1;
    chk("br_sc", b.stall_count, 2);
    nxt(); exi(1, 1, 5); idi(5, 0, 1, 0, 7, 1, 1); #1;
    chk("md_lu_start", b.md_start, 0);
    chk("md_lu_hold", b.pc_hold, 1);
    nxt(); exi(0, 0, 0); #1;
    chk("md_issue", b.md_start, 1);
    chk("md_issue_hold", b.pc_hold, 0);
    for (int i = 1; i <= 5; i++) begin
      nxt(); clr(); idi(7, 0, 1, 0, 8, 1, 0); #1;
      chk($sformatf("raw_hold_%0d", i), b.pc_hold, 1);
      chk($sformatf("raw_busy_%0d", i), b.md_busy, 1);
      chk($sformatf("raw_done_%0d", i), b.md_done, i == 5 ? 1 : 0);
      chk($sformatf("raw_dest_%0d", i), b.md_dest_out, 7);
    end
    nxt(); #1;
    chk("raw_rel_hold", b.pc_hold, 0);
    chk("raw_rel_busy", b.md_busy, 0);
    chk("raw_rel_done", b.md_done, 0);
    chk("raw_sc", b.stall_count, 8);
    nxt(); idi(0, 0, 0, 0, 9, 1, 1); #1;
    chk("st_issue", b.md_start, 1);
    for (int i = 1; i <= 5; i++) begin
      nxt(); idi(0, 0, 0, 0, 3, 1, 1); #1;
      chk($sformatf("st_hold_%0d", i), b.pc_hold, 1);
      chk($sformatf("st_start_%0d", i), b.md_start, 0);
    end
    nxt(); #1;
    chk("st_reissue", b.md_start, 1);
    chk("st_rel_hold", b.pc_hold, 0);
    chk("st_dest", b.md_dest_out, 9);
    for (int i = 1; i <= 5; i++) begin
      nxt(); idi(0, 0, 0, 0, 3, 1, 0); #1;
      chk($sformatf("waw_hold_%0d", i), b.pc_hold, 1);
    end
    chk("waw_dest", b.md_dest_out, 3);
    nxt(); #1;
    chk("waw_rel_hold", b.pc_hold, 0);
    chk("waw_sc", b.stall_count, 18);
    nxt(); idi(0, 0, 0, 0, 0, 1, 1); #1;
    chk("d0_issue", b.md_start, 1);
    nxt(); idi(0, 0, 1, 1, 0, 1, 0); #1;
    chk("d0_hold", b.pc_hold, 0);
    chk("d0_busy", b.md_busy, 1);
    nxt(); clr(); b.branch_taken = 1; #1;
    chk("d0_br_flush", b.ifid_flush, 1);
    chk("d0_br_busy", b.md_busy, 1);
    nxt(); clr();
    nxt();
    nxt(); #1;
    chk("d0_done", b.md_done, 1);
    nxt(); idi(0, 0, 0, 0, 7, 1, 1); #1;
    chk("ab_issue", b.md_start, 1);
    nxt(); clr();
    nxt(); rst = 1;
    nxt(); rst = 0; idi(7, 0, 1, 0, 8, 1, 0); #1;
    chk("ab_busy", b.md_busy, 0);
    chk("ab_hold", b.pc_hold, 0);
    chk("ab_sc", b.stall_count, 0);
    chk("ab_dest", b.md_dest_out, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); #1;
      chk($sformatf("ab_done_%0d", i), b.md_done, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer-side hazard controller for the 5-stage pipeline. It decides when the pipeline must hold or squash because a result cannot be forwarded in time.
- Covers three cases: load-use hazards, a multi-cycle mult/div unit tracked by an internal scoreboard FSM, and taken-branch flushes.
- Sits beside the ID stage. Drives PC / IF-ID hold, IF-ID flush and ID-EX bubble insertion.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit stays busy after issue (legal range 2..15).
- REG_BITS, 5, register specifier width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_BITS  ID source register 1
- id_rt  in  REG_BITS  ID source register 2
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dest  in  REG_BITS  ID destination register
- id_wb_en  in  1  ID instruction writes a register
- id_is_md  in  1  ID instruction is mult/div
- ex_mem_r_en  in  1  EX instruction is a load
- ex_wb_en  in  1  EX instruction writes a register
- ex_dest  in  REG_BITS  EX destination register
- branch_taken  in  1  EX resolved a taken branch
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze IF/ID register
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  clear IF/ID register
- md_start  out  1  issue pulse to mult/div unit
- md_busy  out  1  FSM not IDLE
- md_done  out  1  one-cycle result-ready pulse
- md_dest_out  out  REG_BITS  destination of in-flight mult/div
- stall_count  out  16  saturating count of pc_hold cycles

Behaviour:
- Reset (synchronous): state=IDLE, counter=0, md_dest_out=0, stall_count=0.
  - While rst=1, every combinational output is forced to 0.
- Combinational hazard terms (all include id_valid):
  - lu = ex_mem_r_en & ex_wb_en & ex_dest!=0 & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
  - md_raw = state!=IDLE & md_dest_out!=0 & (rs match with id_use_rs | rt match with id_use_rt).
  - md_waw = state!=IDLE & md_dest_out!=0 & id_wb_en & id_dest==md_dest_out.
  - md_struct = state!=IDLE & id_is_md.
  - stall = lu | md_raw | md_waw | md_struct.
- Priority:
  - branch_taken=1: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0. The ID instruction is squashed and md_start=0 regardless of stall.
  - Else stall=1: pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - Else all four outputs are 0.
- md_start = id_valid & id_is_md & state==IDLE & !stall & !branch_taken.
  - A load-use stall on the md instruction itself therefore delays its issue.
- FSM:
  - IDLE: on md_start, latch id_dest into md_dest_out, set counter=MD_LATENCY-1, go BUSY.
  - BUSY: counter decrements each cycle. When counter==0, go DONE.
  - DONE: md_done=1 for exactly one cycle, go IDLE. md_dest_out holds its value until the next issue.
  - md_busy=1 in BUSY and DONE.
- Timing: md_start at cycle T gives md_busy high at T+1..T+MD_LATENCY+1, with md_done at T+MD_LATENCY+1.
  - RAW, WAW and structural stalls hold through the DONE cycle and release the cycle after.
- A taken branch never affects an mult/div already in flight; it is older than the branch.
- md_dest_out==0 keeps the FSM running but produces no RAW/WAW stalls.
- stall_count increments by 1 on each clock edge where pc_hold=1 and saturates at 16'hFFFF. A flush is not counted.
- Reset mid-BUSY aborts the operation: no md_done, scoreboard cleared next cycle.

Test Plan:
- Load-use: EX load ex_dest=5, ID add reads rs=5 → pc_hold/ifid_hold/idex_bubble=1 for one cycle. With EX bubble next cycle → all 0. stall_count=1.
- Load to r0: ex_dest=0, id_rs=0 → no stall. Load with id_use_rs=0 and matching rs → no stall.
- MD issue with MD_LATENCY=4: md_start at T, dest=7. md_busy high T+1..T+5, md_done pulse only at T+5. ID reading r7 during T+1..T+5 → stalled 5 cycles, proceeds at T+6.
- Structural/WAW: second mult/div, or a write to r7, in ID while busy → stalled until state returns IDLE. Second md_start is asserted on the first IDLE cycle.
- Branch during stall: branch_taken=1 in the same cycle as lu=1 → ifid_flush=1, idex_bubble=1, pc_hold=0, stall_count unchanged.
- Reset mid-operation: rst at T+2 after md_start → next cycle md_busy=0, md_done never pulses, stall_count=0. An ID read of r7 proceeds unstalled.
